limit_updown_counter: RTL

//   Parametrised modulo up/down counter with a runtime-loadable limit register.

---
 rtl/limit_updown_counter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/limit_updown_counter.sv
// ---------------------------------------------------------------------------
// limit_updown_counter
//   Modulo up/down counter with a runtime-loadable limit register. Counts
//   0..limit and wraps (default build), or holds at the ends when
//   LIMIT_COUNTER_SATURATE_EN is defined. The tc output feeds the enable of
//   the next stage, so several instances cascade into multi-digit timers.
//
// Build option
//   LIMIT_COUNTER_SATURATE_EN : defined   -> saturate at 0 / limit, wrap tied 0
//                               undefined -> wrap-around
//
// Parameters
//   WIDTH        counter, data and limit width
//   LIMIT        reset value of the limit register (< 2**WIDTH)
//   RESET_VALUE  reset value of q (<= LIMIT)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   enable      in   count enable / cascade carry-in
//   up          in   1 = count up, 0 = count down
//   preset      in   synchronous load of q from data (clamped to the limit)
//   data        in   preset value
//   limit_load  in   synchronous load of the limit register
//   limit_data  in   new limit value
//   q           out  registered count
//   limit       out  registered limit
//   tc          out  combinational terminal count
//   wrap        out  registered one-cycle pulse after a wrap
// ---------------------------------------------------------------------------
module limit_updown_counter #(
  parameter int WIDTH       = 4,
  parameter int LIMIT       = 9,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             preset,
  input  logic [WIDTH-1:0] data,
  input  logic             limit_load,
  input  logic [WIDTH-1:0] limit_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] limit,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LIMIT_INIT = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] Q_INIT     = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] limit_r;
  logic             wrap_r;

  logic [WIDTH-1:0] limit_eff;
  logic [WIDTH-1:0] preset_val;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             at_top;
  logic             at_bottom;
  logic             out_of_range;

  // A preset in the same cycle as a limit load is clamped against the new
  // limit, so the counter never lands outside the range it will count in.
  assign limit_eff  = limit_load ? limit_data : limit_r;
  assign preset_val = (data > limit_eff) ? limit_eff : data;

  // Counting always looks at the limit held before this edge.
  assign at_top       = (q_r == limit_r);
  assign at_bottom    = (q_r == '0);
  assign out_of_range = (q_r > limit_r);

  always_comb begin
    count_next = q_r;
    wrap_next  = 1'b0;
    if (out_of_range) begin
      // Only reachable after the limit was lowered below q.
`ifdef LIMIT_COUNTER_SATURATE_EN
      count_next = limit_r;
`else
      count_next = up ? '0 : limit_r;
`endif
    end else if (up) begin
      if (at_top) begin
`ifdef LIMIT_COUNTER_SATURATE_EN
        count_next = q_r;
`else
        count_next = '0;
        wrap_next  = 1'b1;
`endif
      end else begin
        count_next = q_r + ONE;
      end
    end else begin
      if (at_bottom) begin
`ifdef LIMIT_COUNTER_SATURATE_EN
        count_next = q_r;
`else
        count_next = limit_r;
        wrap_next  = 1'b1;
`endif
      end else begin
        count_next = q_r - ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r     <= Q_INIT;
      limit_r <= LIMIT_INIT;
      wrap_r  <= 1'b0;
    end else begin
      if (limit_load) begin
        limit_r <= limit_data;
      end
      if (preset) begin
        q_r    <= preset_val;
        wrap_r <= 1'b0;
      end else if (enable) begin
        q_r    <= count_next;
        wrap_r <= wrap_next;
      end else begin
        wrap_r <= 1'b0;
      end
    end
  end

  // With limit==0 both compares are true, so tc simply follows enable.
  assign tc    = enable & (up ? at_top : at_bottom);
  assign q     = q_r;
  assign limit = limit_r;
  assign wrap  = wrap_r;

endmodule
